// File: rtl/gpio_pad_bridge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gpio_pad_bridge
//
// Registered bridge between the Caravel user I/O pads and the fpga250 core
// GPIO ports, with a small Wishbone classic slave for control and status.
//
//   * Pad inputs pass through a SYNC_STAGES-deep synchronizer before reaching
//     the fabric or the IN register; output pads present 0 to the fabric.
//   * Pad outputs are registered; each pad can be overridden by software.
//   * Optional sticky rising-edge capture with write-1-to-clear.
//
// Optional feature macro: GPIO_BRIDGE_EDGE_EN
//   defined   -> EDGE registers (0x20/0x24), edge detect and W1C logic present.
//   undefined -> 0x20/0x24 read 0 and ignore writes (still acked).
//
// Register map (byte offset from BASE_ADDR; LO = pads 31:0, HI = pads above
// 31, zero-extended):
//   0x00/0x04 DIR      RW  1 = pad is an output
//   0x08/0x0C OVR_EN   RW  1 = io_out driven from OVR_VAL instead of fabric
//   0x10/0x14 OVR_VAL  RW
//   0x18/0x1C IN       RO  synchronized pad value
//   0x20/0x24 EDGE     W1C sticky rising-edge flags (input pads only)
//   other offsets in the 256-byte window: acked, read 0, writes ignored.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   wbs_*                  Wishbone classic slave (single-cycle ack)
//   io_in / io_out / io_oeb  pad side
//   fabric_in / fabric_out   fpga core GPIO side
// -----------------------------------------------------------------------------
module gpio_pad_bridge #(
  parameter int                   NUM_PADS    = 38,
  parameter logic [31:0]          BASE_ADDR   = 32'h3000_1000,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [NUM_PADS-1:0]  DIR_RESET   = 38'h3F_FF00_7800
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_PADS-1:0] io_in,
  output logic [NUM_PADS-1:0] io_out,
  output logic [NUM_PADS-1:0] io_oeb,
  output logic [NUM_PADS-1:0] fabric_in,
  input  logic [NUM_PADS-1:0] fabric_out
);

  localparam int W = NUM_PADS;

  // Register index = wbs_adr_i[7:3]; wbs_adr_i[2] selects the LO/HI half.
  typedef enum logic [4:0] {
    R_DIR     = 5'd0,
    R_OVR_EN  = 5'd1,
    R_OVR_VAL = 5'd2,
    R_IN      = 5'd3,
    R_EDGE    = 5'd4
  } reg_sel_e;

  // ---------------------------------------------------------------------------
  // Wishbone decode and handshake
  // ---------------------------------------------------------------------------
  logic        hit;
  logic        req;
  logic        ack_q, ack_d;
  logic        wr_en;
  reg_sel_e    reg_sel;
  logic        half_hi;
  logic [31:0] byte_mask32;
  logic [63:0] wr_mask64;
  logic [63:0] wr_data64;

  assign hit     = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req     = wbs_stb_i & wbs_cyc_i & hit;
  assign reg_sel = reg_sel_e'(wbs_adr_i[7:3]);
  assign half_hi = wbs_adr_i[2];

  // Ack the cycle after a request; the !ack_q term makes a held strobe ack
  // every other cycle.
  assign ack_d = req & ~ack_q;

  // Reset masks an ack already in flight so an interrupted access is never
  // seen as completed; the master reissues it.
  assign wbs_ack_o = ack_q & ~wb_rst_i;

  // The write commits on the edge that closes the ack cycle, using the
  // address/data the master is still holding.
  assign wr_en = wbs_ack_o & req & wbs_we_i;

  assign byte_mask32 = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wr_mask64   = half_hi ? {byte_mask32, 32'h0} : {32'h0, byte_mask32};
  assign wr_data64   = half_hi ? {wbs_dat_i,   32'h0} : {32'h0, wbs_dat_i};

  // Byte-lane merge into a pad-wide register; bits >= NUM_PADS fall away.
  function automatic logic [W-1:0] merge_bytes(input logic [W-1:0] old_val,
                                               input logic [63:0]  data,
                                               input logic [63:0]  mask);
    logic [63:0] ext;
    ext = 64'(old_val);
    ext = (ext & ~mask) | (data & mask);
    return W'(ext);
  endfunction

  // ---------------------------------------------------------------------------
  // Control registers and output path
  // ---------------------------------------------------------------------------
  logic [W-1:0] dir_q,     dir_d;
  logic [W-1:0] ovr_en_q,  ovr_en_d;
  logic [W-1:0] ovr_val_q, ovr_val_d;
  logic [W-1:0] io_out_q,  io_out_d;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dir_d     = dir_q;
    ovr_en_d  = ovr_en_q;
    ovr_val_d = ovr_val_q;
    if (wr_en) begin
      case (reg_sel)
        R_DIR:     dir_d     = merge_bytes(dir_q,     wr_data64, wr_mask64);
        R_OVR_EN:  ovr_en_d  = merge_bytes(ovr_en_q,  wr_data64, wr_mask64);
        R_OVR_VAL: ovr_val_d = merge_bytes(ovr_val_q, wr_data64, wr_mask64);
        default:   ;
      endcase
    end
    // Pad output register is driven regardless of DIR; io_oeb gates it.
    io_out_d = (ovr_en_q & ovr_val_q) | (~ovr_en_q & fabric_out);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and simulation ordering cannot change the result.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q     <= 1'b0;
      dir_q     <= DIR_RESET;
      ovr_en_q  <= '0;
      ovr_val_q <= '0;
      io_out_q  <= '0;
    end else begin
      ack_q     <= ack_d;
      dir_q     <= dir_d;
      ovr_en_q  <= ovr_en_d;
      ovr_val_q <= ovr_val_d;
      io_out_q  <= io_out_d;
    end
  end

  assign io_out = io_out_q;
  assign io_oeb = ~dir_q;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync_val;

  // NOTE: the synchronizer array is reset explicitly (it is a handful of
  // flops, not a RAM) so fabric_in and the edge detector start from a known 0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= io_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_val  = sync_q[SYNC_STAGES-1];
  assign fabric_in = sync_val & ~dir_q;

  // ---------------------------------------------------------------------------
  // Sticky rising-edge capture
  // ---------------------------------------------------------------------------
  logic [W-1:0] edge_rd;

`ifdef GPIO_BRIDGE_EDGE_EN
  logic [W-1:0] edge_q, edge_d;
  logic [W-1:0] sync_prev_q;
  logic [W-1:0] rise;
  logic [W-1:0] clr;

  assign rise = sync_val & ~sync_prev_q & ~dir_q;
  assign clr  = (wr_en && reg_sel == R_EDGE) ? W'(wr_data64 & wr_mask64) : '0;

  // Set is applied after clear, so a coinciding new edge keeps the bit.
  always_comb begin
    edge_d = (edge_q & ~clr) | rise;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      edge_q      <= '0;
      sync_prev_q <= '0;
    end else begin
      edge_q      <= edge_d;
      sync_prev_q <= sync_val;
    end
  end

  assign edge_rd = edge_q;
`else
  assign edge_rd = '0;
`endif

  // ---------------------------------------------------------------------------
  // Read mux; data is forced to 0 outside the ack cycle so the top level can
  // OR this bus with the configuration port.
  // ---------------------------------------------------------------------------
  logic [63:0] rd64;
  logic [31:0] rd32;

  always_comb begin
    rd64 = 64'h0;
    case (reg_sel)
      R_DIR:     rd64 = 64'(dir_q);
      R_OVR_EN:  rd64 = 64'(ovr_en_q);
      R_OVR_VAL: rd64 = 64'(ovr_val_q);
      R_IN:      rd64 = 64'(sync_val);
      R_EDGE:    rd64 = 64'(edge_rd);
      default:   rd64 = 64'h0;
    endcase
    rd32 = half_hi ? rd64[63:32] : rd64[31:0];
  end

  assign wbs_dat_o = wbs_ack_o ? rd32 : 32'h0;

  // Byte-offset bits below the word are not decoded.
  logic unused_adr_lsb;
  assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

endmodule

// File: tb/tb_gpio_pad_bridge.sv
`timescale 1ns/1ps
module tb_gpio_pad_bridge;

  localparam int          NP      = 38;
  localparam logic [31:0] BASE    = 32'h3000_1000;
  localparam logic [63:0] DIR_RST = 64'h3F_FF00_7800;
  localparam logic [63:0] PMASK   = (64'd1 << NP) - 64'd1;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_adr_i, wbs_dat_i;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic [NP-1:0] io_in, io_out, io_oeb, fabric_in, fabric_out;

  gpio_pad_bridge dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .fabric_in  (fabric_in),
    .fabric_out (fabric_out)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
    wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = dat; wbs_sel_i = sel;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    acked = 1'b0; rdat = 32'h0;
    for (int i = 0; i < 4 && !acked; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin acked = 1'b1; rdat = wbs_dat_o; end
    end
    if (acked) begin @(posedge wb_clk_i); #1; end  // edge that commits the write
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r; logic a;
    wb_xfer(BASE + 32'(off), 1'b1, dat, sel, r, a);
    check({tag, "_ack"}, 64'(a), 64'd1);
  endtask

  task automatic rd(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] r; logic a;
    wb_xfer(BASE + 32'(off), 1'b0, 32'h0, 4'h0, r, a);
    check({tag, "_ack"}, 64'(a), 64'd1);
    check(tag, 64'(r), 64'(exp));
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_dir, m_en, m_val, m_edge, m_sync, m_fo;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic hi,
                                        input logic [31:0] d, input logic [3:0] s);
    logic [63:0] r;
    int base;
    r = old;
    base = hi ? 32 : 0;
    for (int k = 0; k < 4; k++)
      if (s[k]) r[base + 8*k +: 8] = d[8*k +: 8];
    return r & PMASK;
  endfunction

  function automatic logic [31:0] model_read(input int word);
    logic [63:0] v;
    case (word >> 1)
      0: v = m_dir;
      1: v = m_en;
      2: v = m_val;
      3: v = m_sync;
      4: v = m_edge;
      default: v = 64'h0;
    endcase
    return word[0] ? v[63:32] : v[31:0];
  endfunction

  task automatic check_pads(input string tag);
    check({tag, "_io_out"},    64'(io_out),    ((m_en & m_val) | (~m_en & m_fo)) & PMASK);
    check({tag, "_io_oeb"},    64'(io_oeb),    ~m_dir & PMASK);
    check({tag, "_fabric_in"}, 64'(fabric_in), m_sync & ~m_dir & PMASK);
  endtask

  initial begin
    logic [31:0] r;
    logic        a;
    logic [5:0]  pat;
    int          nack;

    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
    wbs_adr_i = 0; wbs_dat_i = 0; io_in = '0; fabric_out = '0;
    do_reset();

    // ---- reset state ----
    check("rst_io_oeb",    64'(io_oeb),    ~DIR_RST & PMASK);
    check("rst_io_out",    64'(io_out),    64'h0);
    check("rst_fabric_in", 64'(fabric_in), 64'h0);
    rd("rst_dir_lo", 8'h00, 32'hFF00_7800);
    rd("rst_dir_hi", 8'h04, 32'h0000_003F);

    // ---- input synchronizer latency ----
    wr("dir_lo_clr", 8'h00, 32'h0, 4'hF);
    wr("dir_hi_clr", 8'h04, 32'h0, 4'hF);
    io_in[3] = 1'b1;
    @(posedge wb_clk_i); #1;
    check("sync_1cyc", 64'(fabric_in[3]), 64'd0);
    @(posedge wb_clk_i); #1;
    check("sync_2cyc", 64'(fabric_in[3]), 64'd1);
    rd("in_lo", 8'h18, 32'h0000_0008);
    wr("dir3_set", 8'h00, 32'h0000_0008, 4'h1);
    check("dir3_masks_fabric", 64'(fabric_in[3]), 64'd0);

    // ---- override with byte select ----
    fabric_out = 38'h15_5555_5555;
    wr("ovr_val_lo", 8'h10, 32'hFFFF_FFFF, 4'hF);
    @(posedge wb_clk_i); #1;
    check("ovr_val_only", 64'(io_out), 64'h15_5555_5555);
    wr("ovr_en_lo", 8'h08, 32'h0000_FF00, 4'b0010);
    @(posedge wb_clk_i); #1;
    check("ovr_bytesel", 64'(io_out), 64'h15_5555_FF55);
    rd("ovr_en_rd", 8'h08, 32'h0000_FF00);

    // ---- edge capture / W1C ----
    wr("dir_lo_clr2", 8'h00, 32'h0, 4'hF);
`ifdef GPIO_BRIDGE_EDGE_EN
    wr("edge_clr_all", 8'h20, 32'hFFFF_FFFF, 4'hF);
    io_in[5] = 1'b1;
    repeat (4) @(posedge wb_clk_i); #1;
    rd("edge_set", 8'h20, 32'h0000_0020);
    wr("edge_w1c", 8'h20, 32'h0000_0020, 4'h1);
    rd("edge_cleared", 8'h20, 32'h0);
    io_in[5] = 1'b0;
    repeat (4) @(posedge wb_clk_i); #1;
    // New rise lands on the same edge as the clear commit.
    io_in[5] = 1'b1;
    @(posedge wb_clk_i); #1;
    wr("edge_collide_wr", 8'h20, 32'h0000_0020, 4'h1);
    rd("edge_set_wins", 8'h20, 32'h0000_0020);
`else
    io_in[5] = 1'b1;
    repeat (4) @(posedge wb_clk_i); #1;
    rd("edge_absent", 8'h20, 32'h0);
`endif

    // ---- decode ----
    rd("unmapped_0x40", 8'h40, 32'h0);
    wb_xfer(32'h3000_0000, 1'b0, 32'h0, 4'h0, r, a);
    check("out_of_window_ack", 64'(a), 64'd0);
    check("out_of_window_dat", 64'(wbs_dat_o), 64'h0);
    wbs_adr_i = BASE; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge wb_clk_i); #1;
      pat[5-i] = wbs_ack_o;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("held_stb_pattern", 64'(pat), 64'(6'b101010));

    // ---- reset mid-access ----
    io_in = '0;
    do_reset();
    nack = 0;
    wbs_adr_i = BASE; wbs_we_i = 1'b1; wbs_dat_i = 32'h0; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    #1 if (wbs_ack_o) nack++;
    @(posedge wb_clk_i); #1;
    if (wbs_ack_o) nack++;
    wb_rst_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    check("rst_mid_no_ack", 64'(nack), 64'd0);
    check("rst_mid_io_oeb", 64'(io_oeb), ~DIR_RST & PMASK);
    rd("rst_mid_dir_lo", 8'h00, 32'hFF00_7800);

    // ---- randomized phase against the model ----
    io_in = '0; fabric_out = '0;
    do_reset();
    m_dir = DIR_RST; m_en = 0; m_val = 0; m_edge = 0; m_sync = 0; m_fo = 0;
    for (int it = 0; it < 300; it++) begin
      int          word;
      logic [31:0] d;
      logic [3:0]  s;
      logic [63:0] nin;
      case ($urandom_range(0, 3))
        0, 1: begin
          word = $urandom_range(0, 15);
          d = $urandom; s = 4'($urandom);
          wb_xfer(BASE + 32'(word * 4), 1'b1, d, s, r, a);
          check("rnd_wr_ack", 64'(a), 64'd1);
          case (word >> 1)
            0: m_dir = merge(m_dir, word[0], d, s);
            1: m_en  = merge(m_en,  word[0], d, s);
            2: m_val = merge(m_val, word[0], d, s);
`ifdef GPIO_BRIDGE_EDGE_EN
            4: m_edge = m_edge & ~merge(64'h0, word[0], d, s);
`endif
            default: ;
          endcase
        end
        2: begin
          nin = {$urandom, $urandom} & PMASK;
          m_fo = {$urandom, $urandom} & PMASK;
          io_in = NP'(nin); fabric_out = NP'(m_fo);
          repeat (4) @(posedge wb_clk_i); #1;
`ifdef GPIO_BRIDGE_EDGE_EN
          m_edge = m_edge | (nin & ~m_sync & ~m_dir);
`endif
          m_sync = nin;
        end
        default: begin
          word = $urandom_range(0, 15);
          wb_xfer(BASE + 32'(word * 4), 1'b0, 32'h0, 4'h0, r, a);
          check("rnd_rd_ack", 64'(a), 64'd1);
          check("rnd_rd_data", 64'(r), 64'(model_read(word)));
        end
      endcase
      @(posedge wb_clk_i); #1;
      check_pads("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/gpio_pad_bridge.md
# gpio_pad_bridge

Registered pad-side bridge between the Caravel user I/O pins and the fpga250 core GPIO ports. It resynchronizes pad inputs into the wishbone clock domain before they reach the fabric, registers fabric outputs onto the pads, and exposes a small Wishbone slave for per-pad direction, software output override, live input readback and sticky rising-edge capture. It sits on the same Wishbone bus as the FPGA configuration port, in its own address window.

## Interface
- NUM_PADS, 38: number of user I/O pads bridged (max 64).
- BASE_ADDR, 32'h3000_1000: window base; decode compares wbs_adr_i[31:8] against BASE_ADDR[31:8].
- SYNC_STAGES, 2: input synchronizer depth (≥2).
- DIR_RESET, 38'h3F_FF00_7800: per-pad direction after reset; 1 = output. Default makes pads 11–14 and 24–37 outputs.

- wb_clk_i  in  1  sole clock; all flops on rising edge.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone classic strobe, cycle, write-enable.
- wbs_sel_i  in  4  byte lane enables for writes.
- wbs_adr_i, wbs_dat_i  in  32  address, write data.
- wbs_ack_o  out  1  single-cycle acknowledge.
- wbs_dat_o  out  32  read data; 0 whenever wbs_ack_o is low.
- io_in  in  NUM_PADS  raw pad inputs.
- io_out  out  NUM_PADS  registered pad outputs.
- io_oeb  out  NUM_PADS  output-enable bar; equals ~DIR.
- fabric_in  out  NUM_PADS  synchronized inputs to fpga gpio.
- fabric_out  in  NUM_PADS  fpga gpio outputs.

## Operation
- Registers (byte offset from BASE_ADDR; LO = pads 31:0, HI = pads NUM_PADS-1:32 zero-extended): 0x00/0x04 DIR RW, 0x08/0x0C OVR_EN RW, 0x10/0x14 OVR_VAL RW, 0x18/0x1C IN RO (synchronized pad value), 0x20/0x24 EDGE W1C.
- Writes honor wbs_sel_i per byte. Bits ≥ NUM_PADS read 0; writes to them are ignored.
- Unmapped offsets inside the window: acked, read 0, writes ignored. Outside the window: no ack and wbs_dat_o = 0; the top level ORs acks and data with the configuration port.
- io_out[i] <= OVR_EN[i] ? OVR_VAL[i] : fabric_out[i]. The register is driven regardless of DIR; io_oeb gates it at the pad.
- fabric_in[i] = sync[i] & ~DIR[i]. Output pads present 0 to the fabric.
- EDGE[i] sets when the synchronized value goes 0→1 while DIR[i] = 0. Writing 1 clears the bit. If a set and a clear land in the same cycle, the set wins.

## Timing
- Wishbone: ack is asserted in cycle N+1 when stb&cyc&window-hit in cycle N and ack was low in N. Ack is high for exactly one cycle. A held strobe produces ack every other cycle. Read data is valid in the ack cycle. The write commits on the ack edge.
- Input path: an io_in change reaches the IN register and fabric_in after SYNC_STAGES cycles. The EDGE bit sets one cycle after that.
- Output path: fabric_out or override change → io_out one cycle later. DIR write → io_oeb changes in the cycle after ack.
- Reset (synchronous, wins over everything including an in-flight access):
  - wbs_ack_o = 0, wbs_dat_o = 0.
  - DIR = DIR_RESET, so io_oeb = ~DIR_RESET.
  - OVR_EN = OVR_VAL = 0, io_out = 0.
  - Synchronizer flops = 0, fabric_in = 0, EDGE = 0.
  - An access interrupted by reset is not acked; the master must reissue it.
- No combinational path from io_in to any output.

## Configuration
- GPIO_BRIDGE_EDGE_EN defined: EDGE registers, edge detect flops and W1C logic are present as specified.
- Undefined: offsets 0x20/0x24 read 0 and ignore writes (still acked), and no edge logic is synthesized. All other behaviour is unchanged.

## Test plan
- Reset: assert wb_rst_i 2 cycles → io_oeb = ~38'h3F_FF00_7800, io_out = 0, fabric_in = 0, DIR_LO read = 32'hFF00_7800, DIR_HI read = 32'h3F.
- Input sync: DIR = 0, drive io_in[3] 0→1 → fabric_in[3] rises exactly 2 cycles later and IN_LO bit 3 reads 1. Set DIR[3] = 1 → fabric_in[3] = 0.
- Override with byte select: write OVR_VAL_LO = 32'hFFFF_FFFF, then OVR_EN_LO = 32'h0000_FF00 with sel = 4'b0010 → io_out[15:8] = 8'hFF one cycle after ack; other bits follow fabric_out.
- Edge W1C collision: rising edge on pad 5, read EDGE_LO = 32'h20. Write 32'h20 → reads 0. Repeat with the write coinciding with a new edge → bit stays 1.
- Decode: read at BASE_ADDR + 0x40 → ack with 0. Access at 32'h3000_0000 → no ack in 4 cycles. Back-to-back held strobe → acks in alternate cycles.
- Reset mid-access: assert wb_rst_i in the cycle after stb rises → no ack, DIR unchanged from DIR_RESET.
